// File: rtl/approx_recursive_mult_seq.sv
// Iterative recursive approximate multiplier: one 4x4 digit sub-product per cycle,
// exact or approximate (3x3=7 low block), accumulated into a shifted 2*WIDTH register.
module approx_recursive_mult_seq #(
    parameter int WIDTH = 8,
    parameter int THR_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic [THR_W-1:0]     approx_thr,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   y,
    output logic                 approx_used
);

    localparam int N  = WIDTH / 4;
    localparam int IW = $clog2(N);
    localparam int PW = 2 * WIDTH;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [THR_W-1:0] r_thr;
    logic [PW-1:0]    r_acc;
    logic [PW-1:0]    r_y;
    logic [IW-1:0]    r_i;
    logic [IW-1:0]    r_j;
    logic             r_approx;

    logic             w_accept;
    logic             w_step;
    logic             w_last;
    logic [IW:0]      w_ij;
    logic [3:0]       w_xa;
    logic [3:0]       w_xb;
    logic [7:0]       w_exact;
    logic             w_both3;
    logic             w_apx;
    logic             w_diff;
    logic [7:0]       w_cell;
    logic [PW-1:0]    w_term;
    logic [PW-1:0]    w_acc_nxt;

    // Current digit pair (i,j) and its weighted sub-product
    assign w_last    = (r_i == IW'(N - 1)) && (r_j == IW'(N - 1));
    assign w_ij      = {1'b0, r_i} + {1'b0, r_j};
    assign w_xa      = 4'(r_a >> {r_i, 2'b00});
    assign w_xb      = 4'(r_b >> {r_j, 2'b00});
    assign w_exact   = {4'b0000, w_xa} * {4'b0000, w_xb};
    assign w_both3   = (&w_xa[1:0]) & (&w_xb[1:0]);
    assign w_apx     = 32'(w_ij) < 32'(r_thr);
    assign w_diff    = w_apx & w_both3;
    assign w_cell    = w_diff ? (w_exact - 8'd2) : w_exact;
    assign w_term    = PW'(w_cell) << {w_ij, 2'b00};
    assign w_acc_nxt = r_acc + w_term;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        w_accept  = 1'b0;
        w_step    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_accept = 1'b1;
                    w_next   = S_CALC;
                end
            end
            S_CALC: begin
                w_step = 1'b1;
                if (w_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_thr    <= '0;
            r_acc    <= '0;
            r_y      <= '0;
            r_i      <= '0;
            r_j      <= '0;
            r_approx <= 1'b0;
        end else if (w_accept) begin
            r_a      <= a;
            r_b      <= b;
            r_thr    <= approx_thr;
            r_acc    <= '0;
            r_i      <= '0;
            r_j      <= '0;
            r_approx <= 1'b0;
        end else if (w_step) begin
            r_acc <= w_acc_nxt;
            if (w_diff) begin
                r_approx <= 1'b1;
            end
            // y only moves when a result completes, so it holds through IDLE
            if (w_last) begin
                r_y <= w_acc_nxt;
            end
            if (r_j == IW'(N - 1)) begin
                r_j <= '0;
                r_i <= r_i + 1'b1;
            end else begin
                r_j <= r_j + 1'b1;
            end
        end
    end

    assign y           = r_y;
    assign approx_used = r_approx;

endmodule
